atm_multi_account: RTL

ATM_MULTI_ACCOUNT -- requirements
Module: atm_multi_account

---
 rtl/atm_multi_account_if.sv | 45 ++++
 rtl/atm_multi_account.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_multi_account_if.sv
// ---------------------------------------------------------------------------
// atm_multi_account_if
// Customer-side signal bundle of the multi-account ATM controller.
//   master : the card reader / keypad side (drives card, PIN and operations)
//   slave  : the controller (drives results and session status)
// Signals:
//   cardIn            card present (level)
//   acct_id           account selector, taken when the card is accepted
//   pin / pin_valid   PIN attempt, one-cycle strobe
//   op_valid / opCode operation strobe: 00 deposit, 01 withdraw, 10 balance, 11 eject
//   inputAmount       operand for deposit / withdraw
//   balance_out       balance of the active account, valid while done=1
//   done              one-cycle completion pulse
//   err               result code, valid while done=1
//   card_retained     high from retention until reset
//   ATMUsageFinished  one-cycle pulse when a session ends
// ---------------------------------------------------------------------------
interface atm_multi_account_if #(
  parameter int BAL_W = 32,
  parameter int PIN_W = 4,
  parameter int AW    = 2
);
  logic             cardIn;
  logic [AW-1:0]    acct_id;
  logic [PIN_W-1:0] pin;
  logic             pin_valid;
  logic             op_valid;
  logic [1:0]       opCode;
  logic [BAL_W-1:0] inputAmount;
  logic [BAL_W-1:0] balance_out;
  logic             done;
  logic [2:0]       err;
  logic             card_retained;
  logic             ATMUsageFinished;

  modport master (
    output cardIn, acct_id, pin, pin_valid, op_valid, opCode, inputAmount,
    input  balance_out, done, err, card_retained, ATMUsageFinished
  );

  modport slave (
    input  cardIn, acct_id, pin, pin_valid, op_valid, opCode, inputAmount,
    output balance_out, done, err, card_retained, ATMUsageFinished
  );
endinterface

// File: rtl/atm_multi_account.sv
// ---------------------------------------------------------------------------
// atm_multi_account
// Session controller for an ATM serving N_ACCT accounts. A card selects an
// account, the PIN is verified (card retained after MAX_TRIES misses), then
// deposit / withdraw / balance operations run until eject, card removal or
// an idle timeout. Balances live in a register array reset to BAL_INIT.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    atm_multi_account_if.slave (card, PIN, operations, results)
// ---------------------------------------------------------------------------
module atm_multi_account #(
  parameter int                      BAL_W     = 32,
  parameter int                      PIN_W     = 4,
  parameter int                      N_ACCT    = 4,
  parameter int                      MAX_TRIES = 3,
  parameter int                      TIMEOUT   = 255,
  parameter logic [BAL_W-1:0]        BAL_INIT  = 32'h000F4240,
  parameter logic [N_ACCT*PIN_W-1:0] PIN_INIT  = {N_ACCT{4'b1010}}
) (
  input logic                 clk,
  input logic                 reset,
  atm_multi_account_if.slave  bus
);

  localparam int AW    = (N_ACCT > 1) ? $clog2(N_ACCT) : 1;
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTER_PIN, S_CHOOSE, S_EXEC, S_REPORT, S_EJECT, S_RETAIN
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE, ERR_BAD_PIN, ERR_FUNDS, ERR_OVERFLOW, ERR_RETAINED, ERR_TIMEOUT
  } err_t;

  typedef enum logic [1:0] {
    OP_DEPOSIT, OP_WITHDRAW, OP_BALANCE, OP_EJECT
  } op_t;

  state_t           r_state,    w_state_nxt;
  logic [AW-1:0]    r_acct,     w_acct_nxt;
  logic [TRY_W-1:0] r_tries,    w_tries_nxt;
  logic [TMR_W-1:0] r_timer,    w_timer_nxt;
  op_t              r_op,       w_op_nxt;
  logic [BAL_W-1:0] r_amt,      w_amt_nxt;
  logic             r_done,     w_done_nxt;
  err_t             r_err,      w_err_nxt;
  logic [BAL_W-1:0] r_bal_out,  w_bal_out_nxt;
  logic             r_retained, w_retained_nxt;
  logic             r_finished, w_finished_nxt;

  logic [BAL_W-1:0] r_bal [N_ACCT];
  logic             w_wr_en;
  logic [BAL_W-1:0] w_wr_data;

  logic [BAL_W-1:0] w_cur_bal;
  logic [BAL_W:0]   w_sum;
  logic             w_pin_ok;
  logic             w_timed_out;
  logic             w_last_try;

  assign w_cur_bal   = r_bal[r_acct];
  // Extra carry bit exposes deposit overflow without a second comparator.
  assign w_sum       = {1'b0, w_cur_bal} + {1'b0, r_amt};
  assign w_pin_ok    = (bus.pin == PIN_INIT[int'(r_acct) * PIN_W +: PIN_W]);
  // r_timer holds the idle cycles already spent, so this cycle is the last one.
  assign w_timed_out = (r_timer == TMR_W'(TIMEOUT - 1));
  assign w_last_try  = (r_tries == TRY_W'(MAX_TRIES - 1));

  always_comb begin
    // NOTE: every variable gets a default before the case; a path that left
    // one unassigned would infer a latch.
    w_state_nxt    = r_state;
    w_acct_nxt     = r_acct;
    w_tries_nxt    = r_tries;
    w_timer_nxt    = '0;
    w_op_nxt       = r_op;
    w_amt_nxt      = r_amt;
    w_done_nxt     = 1'b0;
    w_err_nxt      = ERR_NONE;
    w_bal_out_nxt  = '0;
    w_retained_nxt = r_retained;
    w_finished_nxt = 1'b0;
    w_wr_en        = 1'b0;
    w_wr_data      = w_cur_bal;

    case (r_state)
      S_IDLE: begin
        if (bus.cardIn) begin
          w_acct_nxt  = bus.acct_id;
          w_tries_nxt = '0;
          w_state_nxt = S_ENTER_PIN;
        end
      end

      S_ENTER_PIN: begin
        if (!bus.cardIn) begin
          w_state_nxt    = S_EJECT;
          w_finished_nxt = 1'b1;
        end else if (bus.pin_valid) begin
          if (w_pin_ok) begin
            w_state_nxt = S_CHOOSE;
          end else if (w_last_try) begin
            w_tries_nxt    = r_tries + TRY_W'(1);
            w_state_nxt    = S_RETAIN;
            w_retained_nxt = 1'b1;
            w_done_nxt     = 1'b1;
            w_err_nxt      = ERR_RETAINED;
            w_finished_nxt = 1'b1;
          end else begin
            w_tries_nxt = r_tries + TRY_W'(1);
            w_done_nxt  = 1'b1;
            w_err_nxt   = ERR_BAD_PIN;
          end
        end else if (w_timed_out) begin
          w_state_nxt    = S_EJECT;
          w_done_nxt     = 1'b1;
          w_err_nxt      = ERR_TIMEOUT;
          w_finished_nxt = 1'b1;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end

      S_CHOOSE: begin
        if (!bus.cardIn) begin
          w_state_nxt    = S_EJECT;
          w_finished_nxt = 1'b1;
        end else if (bus.op_valid) begin
          w_op_nxt  = op_t'(bus.opCode);
          w_amt_nxt = bus.inputAmount;
          if (op_t'(bus.opCode) == OP_EJECT) begin
            w_state_nxt    = S_EJECT;
            w_finished_nxt = 1'b1;
          end else begin
            w_state_nxt = S_EXEC;
          end
        end else if (w_timed_out) begin
          w_state_nxt    = S_EJECT;
          w_done_nxt     = 1'b1;
          w_err_nxt      = ERR_TIMEOUT;
          w_finished_nxt = 1'b1;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end

      S_EXEC: begin
        // Card pulled while the operation is in flight: drop the result.
        if (!bus.cardIn) begin
          w_state_nxt    = S_EJECT;
          w_finished_nxt = 1'b1;
        end else begin
          w_state_nxt   = S_REPORT;
          w_done_nxt    = 1'b1;
          w_bal_out_nxt = w_cur_bal;
          case (r_op)
            OP_DEPOSIT: begin
              if (w_sum[BAL_W]) begin
                w_err_nxt = ERR_OVERFLOW;
              end else begin
                w_wr_en       = 1'b1;
                w_wr_data     = w_sum[BAL_W-1:0];
                w_bal_out_nxt = w_sum[BAL_W-1:0];
              end
            end
            OP_WITHDRAW: begin
              if (r_amt > w_cur_bal) begin
                w_err_nxt = ERR_FUNDS;
              end else begin
                w_wr_en       = 1'b1;
                w_wr_data     = w_cur_bal - r_amt;
                w_bal_out_nxt = w_cur_bal - r_amt;
              end
            end
            default: ;
          endcase
        end
      end

      // done/err/balance_out were registered on entry; hold them one cycle only.
      S_REPORT: w_state_nxt = S_CHOOSE;

      S_EJECT: begin
        if (!bus.cardIn) w_state_nxt = S_IDLE;
      end

      S_RETAIN: w_state_nxt = S_RETAIN;

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_acct     <= '0;
      r_tries    <= '0;
      r_timer    <= '0;
      r_op       <= OP_DEPOSIT;
      r_amt      <= '0;
      r_done     <= 1'b0;
      r_err      <= ERR_NONE;
      r_bal_out  <= '0;
      r_retained <= 1'b0;
      r_finished <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from pre-edge values,
      // independent of statement order.
      r_state    <= w_state_nxt;
      r_acct     <= w_acct_nxt;
      r_tries    <= w_tries_nxt;
      r_timer    <= w_timer_nxt;
      r_op       <= w_op_nxt;
      r_amt      <= w_amt_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_bal_out  <= w_bal_out_nxt;
      r_retained <= w_retained_nxt;
      r_finished <= w_finished_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: this array is deliberately reset: every account must return to
      // its opening balance, so it stays in flops rather than a RAM macro.
      for (int i = 0; i < N_ACCT; i++) r_bal[i] <= BAL_INIT;
    end else if (w_wr_en) begin
      r_bal[r_acct] <= w_wr_data;
    end
  end

  assign bus.balance_out      = r_bal_out;
  assign bus.done             = r_done;
  assign bus.err              = r_err;
  assign bus.card_retained    = r_retained;
  assign bus.ATMUsageFinished = r_finished;

endmodule
